// File: rtl/ql_wiz_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// ql_wiz_bus_ctrl_if
// Bundle of QL expansion-bus and W5300-side signals handled by
// ql_wiz_bus_ctrl.
//   master : the QL bus / board side (drives address, strobes, wr_data, wizintl)
//   slave  : the controller (drives buffer control, DTACK, W5300 strobes, IRQ)
// Signals:
//   address, asl, dsl, rdwl, wr_data : QL bus request
//   wizintl                          : W5300 interrupts, active low
//   dbdir, dbenl, dtackl, dsmcl      : data buffer / bus handshake
//   wizcsl, wizrdl, wizwrl, wizrstl  : W5300 chip selects, strobes, resets
//   busy, irql                       : status and QL interrupt request
// ---------------------------------------------------------------------------
interface ql_wiz_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_CH     = 2
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  asl;
    logic                  dsl;
    logic                  rdwl;
    logic [NUM_CH-1:0]     wr_data;
    logic [NUM_CH-1:0]     wizintl;
    logic                  dbdir;
    logic                  dbenl;
    logic                  dtackl;
    logic                  dsmcl;
    logic [NUM_CH-1:0]     wizcsl;
    logic                  wizrdl;
    logic                  wizwrl;
    logic [NUM_CH-1:0]     wizrstl;
    logic                  busy;
    logic                  irql;

    modport master (
        output address, asl, dsl, rdwl, wr_data, wizintl,
        input  dbdir, dbenl, dtackl, dsmcl, wizcsl, wizrdl, wizwrl, wizrstl, busy, irql
    );

    modport slave (
        input  address, asl, dsl, rdwl, wr_data, wizintl,
        output dbdir, dbenl, dtackl, dsmcl, wizcsl, wizrdl, wizwrl, wizrstl, busy, irql
    );
endinterface

// File: rtl/ql_wiz_bus_ctrl.sv
// ---------------------------------------------------------------------------
// ql_wiz_bus_ctrl
// QL expansion-bus controller for NUM_CH W5300 devices. Decodes a 16-byte card
// window at BASE_ADDR, drives per-channel chip selects and read/write strobes
// held for WAIT_CYCLES before returning DTACK, enforces RECOVER_CYCLES idle
// cycles between accesses, and generates counted per-channel reset pulses when
// RESET_OFFSET is written.
// Ports:
//   clk    : system clock
//   resetl : asynchronous active-low reset
//   bus    : ql_wiz_bus_ctrl_if.slave (bus request in, handshake/W5300 out)
// Optional feature macro: WIZ_IRQ_LATCH_EN
//   defined   - wizintl falling edges latch per-channel pending bits that drive
//               irql low; writing offset 4'hD with wr_data[n]=1 clears bit n.
//   undefined - wizintl ignored, irql tied high.
// ---------------------------------------------------------------------------
module ql_wiz_bus_ctrl #(
    parameter int                    ADDR_WIDTH     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 10'h310,
    parameter int                    NUM_CH         = 2,
    parameter int                    WAIT_CYCLES    = 3,
    parameter int                    RECOVER_CYCLES = 2,
    parameter int                    RESET_CYCLES   = 200,
    parameter logic [3:0]            RESET_OFFSET   = 4'hE
) (
    input  logic              clk,
    input  logic              resetl,
    ql_wiz_bus_ctrl_if.slave  bus
);

    localparam int RW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    logic                  asl_s1_r, asl_s2_r, dsl_s1_r, dsl_s2_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  rdwl_r;
    state_t                state_r, state_s;
    logic [3:0]            wait_cnt_r, wait_cnt_s;
    logic [3:0]            offset_s;
    logic                  in_window_s, rst_write_s, rst_hit_s, active_s, strobe_s;
    logic [NUM_CH-1:0]     in_rst_s;
    logic [RW-1:0]         rst_cnt_r [NUM_CH];
    logic [RW-1:0]         rst_cnt_s [NUM_CH];
    logic [NUM_CH-1:0]     wizrstl_r;
    logic                  dbenl_r, dbenl_s, dtackl_r, dtackl_s, busy_r, busy_s;
    logic                  wizrdl_r, wizrdl_s, wizwrl_r, wizwrl_s;
    logic [NUM_CH-1:0]     wizcsl_r, wizcsl_s;

    // Motherboard decode inhibit and buffer direction follow the live bus.
    assign bus.dsmcl = !bus.asl && (bus.address[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign bus.dbdir = bus.rdwl;

    // Strobe synchronisers; address/direction captured on the edge synced asl falls.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            asl_s1_r <= 1'b1;
            asl_s2_r <= 1'b1;
            dsl_s1_r <= 1'b1;
            dsl_s2_r <= 1'b1;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            rdwl_r   <= 1'b1;
        end else begin
            asl_s1_r <= bus.asl;
            asl_s2_r <= asl_s1_r;
            dsl_s1_r <= bus.dsl;
            dsl_s2_r <= dsl_s1_r;
            if (asl_s2_r && !asl_s1_r) begin
                addr_r <= bus.address;
                rdwl_r <= bus.rdwl;
            end
        end
    end

    // Window decode of the captured address and per-channel reset status.
    always_comb begin
        offset_s    = addr_r[3:0];
        in_window_s = (addr_r[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) && !asl_s2_r;
        rst_write_s = (offset_s == RESET_OFFSET) && !rdwl_r;
        rst_hit_s   = (state_r == ST_SETUP) && rst_write_s;
        for (int n = 0; n < NUM_CH; n++) begin
            in_rst_s[n] = (rst_cnt_r[n] != {RW{1'b0}});
        end
    end

    // FSM state and shared wait/recover counter registers.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_window_s && !dsl_s2_r) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s    = ST_STROBE;
                wait_cnt_s = 4'(WAIT_CYCLES - 1);
            end
            ST_STROBE: begin
                if (wait_cnt_r == 4'd0) begin
                    state_s = ST_ACK;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                // Completion is governed only by dsl, even if asl already rose.
                if (dsl_s2_r) begin
                    if (RECOVER_CYCLES == 0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s    = ST_RECOVER;
                        wait_cnt_s = 4'(RECOVER_CYCLES - 1);
                    end
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_RECOVER: begin
                if (wait_cnt_r == 4'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so the registered outputs line up with the state.
    always_comb begin
        active_s = (state_s == ST_SETUP) || (state_s == ST_STROBE) || (state_s == ST_ACK);
        dbenl_s  = !active_s;
        dtackl_s = (state_s != ST_ACK);
        busy_s   = (state_s != ST_IDLE);
        strobe_s = ((state_s == ST_STROBE) || (state_s == ST_ACK)) && !rst_write_s;
        wizrdl_s = !(strobe_s && rdwl_r);
        wizwrl_s = !(strobe_s && !rdwl_r);
        if (!active_s) begin
            wizcsl_s = {NUM_CH{1'b1}};
        end else if (state_r == ST_IDLE) begin
            // Select decided once on entry; a channel in reset is never selected.
            for (int n = 0; n < NUM_CH; n++) begin
                wizcsl_s[n] = !((offset_s == 4'(n)) && !in_rst_s[n]);
            end
        end else begin
            wizcsl_s = wizcsl_r;
        end
    end

    // Registered handshake and W5300 strobe outputs.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            dbenl_r  <= 1'b1;
            dtackl_r <= 1'b1;
            busy_r   <= 1'b0;
            wizrdl_r <= 1'b1;
            wizwrl_r <= 1'b1;
            wizcsl_r <= {NUM_CH{1'b1}};
        end else begin
            dbenl_r  <= dbenl_s;
            dtackl_r <= dtackl_s;
            busy_r   <= busy_s;
            wizrdl_r <= wizrdl_s;
            wizwrl_r <= wizwrl_s;
            wizcsl_r <= wizcsl_s;
        end
    end

    // Per-channel reset counters: reload on a reset write, otherwise count down to zero.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (rst_hit_s && bus.wr_data[n]) begin
                rst_cnt_s[n] = RW'(RESET_CYCLES);
            end else if (in_rst_s[n]) begin
                rst_cnt_s[n] = rst_cnt_r[n] - {{(RW-1){1'b0}}, 1'b1};
            end else begin
                rst_cnt_s[n] = rst_cnt_r[n];
            end
        end
    end

    // Reset counter registers; the power-up pulse runs from the reset load value.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            for (int n = 0; n < NUM_CH; n++) begin
                rst_cnt_r[n] <= RW'(RESET_CYCLES);
            end
            wizrstl_r <= {NUM_CH{1'b0}};
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                rst_cnt_r[n] <= rst_cnt_s[n];
                wizrstl_r[n] <= (rst_cnt_s[n] == {RW{1'b0}});
            end
        end
    end

    assign bus.dbenl   = dbenl_r;
    assign bus.dtackl  = dtackl_r;
    assign bus.busy    = busy_r;
    assign bus.wizrdl  = wizrdl_r;
    assign bus.wizwrl  = wizwrl_r;
    assign bus.wizcsl  = wizcsl_r;
    assign bus.wizrstl = wizrstl_r;

`ifdef WIZ_IRQ_LATCH_EN
    localparam logic [3:0] IRQ_CLR_OFFSET = 4'hD;

    logic [NUM_CH-1:0] int_s1_r, int_s2_r, int_d_r, pending_r, pending_s, irq_clr_s;
    logic              irql_r;

    // Pending latch: reset holds clear, a new falling edge beats a coincident clear.
    always_comb begin
        if ((state_r == ST_SETUP) && !rdwl_r && (offset_s == IRQ_CLR_OFFSET)) begin
            irq_clr_s = bus.wr_data;
        end else begin
            irq_clr_s = {NUM_CH{1'b0}};
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (in_rst_s[n]) begin
                pending_s[n] = 1'b0;
            end else if (int_d_r[n] && !int_s2_r[n]) begin
                pending_s[n] = 1'b1;
            end else if (irq_clr_s[n]) begin
                pending_s[n] = 1'b0;
            end else begin
                pending_s[n] = pending_r[n];
            end
        end
    end

    // Interrupt synchronisers, edge-detect delay, pending bits and irql register.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            int_s1_r  <= {NUM_CH{1'b1}};
            int_s2_r  <= {NUM_CH{1'b1}};
            int_d_r   <= {NUM_CH{1'b1}};
            pending_r <= {NUM_CH{1'b0}};
            irql_r    <= 1'b1;
        end else begin
            int_s1_r  <= bus.wizintl;
            int_s2_r  <= int_s1_r;
            int_d_r   <= int_s2_r;
            pending_r <= pending_s;
            irql_r    <= !(|pending_s);
        end
    end

    assign bus.irql = irql_r;
`else
    logic [NUM_CH-1:0] unused_wizintl_s;
    assign unused_wizintl_s = bus.wizintl;
    assign bus.irql         = 1'b1;
`endif

endmodule
